// File: rtl/zynq_axi_pkg.sv
// Shared AXI constants and types for the MAXI0 read-side arbiter.
package zynq_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_64B   = 3'd3;
  localparam logic [3:0] CACHE_DEF  = 4'b0011;
  localparam int         AXI_ID_W   = 12;
  localparam int         AXI_ADDR_W = 32;
  localparam int         AXI_DATA_W = 64;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [AXI_ID_W-1:0]   id;
  } axi_ar_t;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_t;

endpackage

// File: rtl/zynq_axi_rd_arbiter_rr_arbiter.sv
// Round-robin pick: first eligible index at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import zynq_axi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_vld,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the closest eligible index wins;
  // NUM_REQ is a power of two, so IDX_W-bit addition wraps naturally.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = ptr + IDX_W'(off);
      if (eligible[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/zynq_axi_rd_arbiter.sv
// Shares the MAXI0 AR/R channels among NUM_REQ read requesters, ARID = requester index.
// Optional performance counters enabled with `define ZYNQ_RD_ARB_PERF_EN.
module zynq_axi_rd_arbiter
  import zynq_axi_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [NUM_REQ*32-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]  req_arlen,
  input  logic [NUM_REQ-1:0]    req_arvalid,
  output logic [NUM_REQ-1:0]    req_arready,
  output logic [63:0]           req_rdata,
  output logic                  req_rlast,
  output logic [1:0]            req_rresp,
  output logic [NUM_REQ-1:0]    req_rvalid,
  input  logic [NUM_REQ-1:0]    req_rready,
  output logic [31:0]           m_araddr,
  output logic [7:0]            m_arlen,
  output logic [11:0]           m_arid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic [3:0]            m_arcache,
  output logic [2:0]            m_arprot,
  output logic [3:0]            m_arqos,
  output logic [1:0]            m_arlock,
  output logic                  m_aruser,
  output logic [3:0]            m_arregion,
  input  logic [63:0]           m_rdata,
  input  logic                  m_rlast,
  input  logic [1:0]            m_rresp,
  input  logic [11:0]           m_rid,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  err_rid
`ifdef ZYNQ_RD_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0] perf_bursts,
  output logic [31:0]           perf_stall
`endif
);

  ar_state_t        state, state_nxt;
  axi_ar_t          ar_q;
  logic [CNT_W-1:0] cnt [NUM_REQ];
  logic [IDX_W-1:0] rr_ptr;
  logic [NUM_REQ-1:0] eligible;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic             grant;
  logic [IDX_W-1:0] rid_k;
  logic             rid_bad;
  logic             rlast_done;
  logic             underflow;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_arvalid[i] && (cnt[i] < CNT_W'(MAX_OUTST));
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );

  // AR stage: IDLE grants straight into the 1-entry register, BUSY presents it.
  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    req_arready = '0;
    case (state)
      AR_IDLE: begin
        if (gnt_vld) begin
          grant                = 1'b1;
          req_arready[gnt_idx] = 1'b1;
          state_nxt            = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (m_arready) state_nxt = AR_IDLE;
      end
      default: state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state  <= AR_IDLE;
      rr_ptr <= '0;
      ar_q   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        rr_ptr      <= gnt_idx + 1'b1;
        ar_q.addr   <= req_araddr[gnt_idx*32 +: 32];
        ar_q.len    <= req_arlen[gnt_idx*8 +: 8];
        ar_q.id     <= AXI_ID_W'(gnt_idx);
      end
    end
  end

  assign m_arvalid  = (state == AR_BUSY);
  assign m_araddr   = ar_q.addr;
  assign m_arlen    = ar_q.len;
  assign m_arid     = ar_q.id;
  assign m_arsize   = SIZE_64B;
  assign m_arburst  = BURST_INCR;
  assign m_arcache  = CACHE_DEF;
  assign m_arprot   = '0;
  assign m_arqos    = '0;
  assign m_arlock   = '0;
  assign m_aruser   = 1'b0;
  assign m_arregion = '0;

  // R path: zero-latency steering by the low RID bits; bad upper bits are sunk.
  assign rid_k      = m_rid[IDX_W-1:0];
  assign rid_bad    = |m_rid[AXI_ID_W-1:IDX_W];
  assign req_rvalid = (m_rvalid && !rid_bad) ? (NUM_REQ'(1) << rid_k) : '0;
  assign m_rready   = rid_bad ? 1'b1 : req_rready[rid_k];
  assign req_rdata  = m_rdata;
  assign req_rlast  = m_rlast;
  assign req_rresp  = m_rresp;
  assign rlast_done = m_rvalid && m_rready && m_rlast && !rid_bad;
  assign underflow  = rlast_done && (cnt[rid_k] == '0) && !(grant && (gnt_idx == rid_k));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((grant && gnt_idx == IDX_W'(i)) && !(rlast_done && rid_k == IDX_W'(i))) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (!(grant && gnt_idx == IDX_W'(i)) && (rlast_done && rid_k == IDX_W'(i))
                     && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      err_rid <= 1'b0;
    end else if ((m_rvalid && rid_bad) || underflow) begin
      err_rid <= 1'b1;
    end
  end

`ifdef ZYNQ_RD_ARB_PERF_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      perf_bursts <= '0;
      perf_stall  <= '0;
    end else begin
      if (grant) begin
        perf_bursts[gnt_idx*32 +: 32] <= perf_bursts[gnt_idx*32 +: 32] + 32'd1;
      end
      if (m_arvalid && !m_arready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
